ps2_keypad_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_rx_frame.sv | 172 +++++++++++++++++
 rtl/ps2_keypad_decoder.sv | 139 +++++++++++++
 tb/tb_ps2_keypad_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keypad decoder.
`timescale 1ns/1ps
package ps2_pkg;

    // Scan-code prefixes that modify the following code byte.
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    // Default key mapping: key0=W, key1=A, key2=S, key3=D.
    localparam logic [31:0] PS2_DEFAULT_KEY_CODES = 32'h231B1C1D;

    // Receive frame position.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // True when the data byte plus its parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchroniser, clock glitch filter, frame FSM
// and inter-edge timeout. Emits one byte_valid strobe per good frame and
// one err strobe per bad or aborted frame.
`timescale 1ns/1ps
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [CNT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    logic                   fe_q, fe_d;

    frame_state_t           state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q, err_d;

    logic                   clk_s;
    logic                   din;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign din   = data_sync_q[SYNC_STAGES-1];

    // Synchroniser shift and glitch filter: the filtered clock flips only
    // after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fe_d = filt_q & ~filt_d;
    end

    // Synchroniser and filter state; lines idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            fe_q        <= fe_d;
        end
    end

    // Frame FSM next state, advancing on each filtered falling edge, with
    // the timeout overriding everything while a frame is in progress.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fe_q) begin
                    if (!din) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fe_q) begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe_q) begin
                    parity_d = din;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe_q) begin
                    if (!din || !odd_parity_ok(shift_q, parity_q)) begin
                        err_d = 1'b1;
                    end else begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (fe_q) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Frame FSM state and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard front end: frame receiver, F0/E0 prefix decode, and a
// per-key held/make map for a configurable set of non-extended codes.
`timescale 1ns/1ps
module ps2_keypad_decoder
    import ps2_pkg::*;
#(
    parameter int                      SYNC_STAGES = 2,
    parameter int                      FILTER_LEN  = 8,
    parameter int                      TIMEOUT_CYC = 50000,
    parameter int                      NUM_KEYS    = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES   = PS2_DEFAULT_KEY_CODES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_make,
    output logic                scan_valid,
    output logic [7:0]          scan_code,
    output logic                scan_break,
    output logic                scan_ext,
    output logic                frame_err
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_err;
    logic [NUM_KEYS-1:0] key_hit;

    logic                brk_q, brk_d;
    logic                ext_q, ext_d;
    logic                scan_valid_q, scan_valid_d;
    logic [7:0]          scan_code_q, scan_code_d;
    logic                scan_break_q, scan_break_d;
    logic                scan_ext_q, scan_ext_d;
    logic                frame_err_q, frame_err_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [NUM_KEYS-1:0] key_make_q, key_make_d;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    // Each key compares the received byte against its own code, so keys
    // sharing a code all respond.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_hit
            assign key_hit[gi] = (rx_byte == KEY_CODES[8*gi +: 8]);
        end
    endgenerate

    // Prefix tracking, scan-code output and key map update.
    always_comb begin
        brk_d        = brk_q;
        ext_d        = ext_q;
        scan_valid_d = 1'b0;
        scan_code_d  = scan_code_q;
        scan_break_d = scan_break_q;
        scan_ext_d   = scan_ext_q;
        frame_err_d  = rx_err;
        key_down_d   = key_down_q;
        key_make_d   = '0;

        if (rx_err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                scan_valid_d = 1'b1;
                scan_code_d  = rx_byte;
                scan_break_d = brk_q;
                scan_ext_d   = ext_q;
                brk_d        = 1'b0;
                ext_d        = 1'b0;
                if (!ext_q) begin
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (key_hit[i]) begin
                            if (brk_q) begin
                                key_down_d[i] = 1'b0;
                            end else begin
                                key_down_d[i] = 1'b1;
                                key_make_d[i] = ~key_down_q[i];
                            end
                        end
                    end
                end
            end
        end
    end

    // Decoder output and prefix registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_code_q  <= 8'h00;
            scan_break_q <= 1'b0;
            scan_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            key_down_q   <= '0;
            key_make_q   <= '0;
        end else begin
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            scan_valid_q <= scan_valid_d;
            scan_code_q  <= scan_code_d;
            scan_break_q <= scan_break_d;
            scan_ext_q   <= scan_ext_d;
            frame_err_q  <= frame_err_d;
            key_down_q   <= key_down_d;
            key_make_q   <= key_make_d;
        end
    end

    assign key_down   = key_down_q;
    assign key_make   = key_make_q;
    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign scan_break = scan_break_q;
    assign scan_ext   = scan_ext_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Scoreboard bench for ps2_keypad_decoder: directed PS/2 frames push
// hand-computed expected events; a monitor pops them whenever the DUT
// presents scan_valid or frame_err.
`timescale 1ns/1ps
module tb_ps2_keypad_decoder;

    localparam int CLK_HALF    = 250;     // 2 MHz system clock
    localparam int PS2_H       = 15000;   // 30 us PS/2 period
    localparam int PS2_Q       = 7500;
    localparam int TIMEOUT_CYC = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key_down;
    logic [3:0] key_make;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       scan_break;
    logic       scan_ext;
    logic       frame_err;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [3:0] kd;
        logic [3:0] km;
    } ev_t;

    ev_t exp_q[$];

    ps2_keypad_decoder #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .NUM_KEYS    (4),
        .KEY_CODES   (32'h231B1C1D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_down   (key_down),
        .key_make   (key_make),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .scan_break (scan_break),
        .scan_ext   (scan_ext),
        .frame_err  (frame_err)
    );

    always #CLK_HALF clk = ~clk;

    task automatic exp_scan(input logic [7:0] code, input logic brk, input logic ext,
                            input logic [3:0] kd, input logic [3:0] km);
        ev_t e;
        e.is_err = 1'b0; e.code = code; e.brk = brk; e.ext = ext; e.kd = kd; e.km = km;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0; e.kd = 4'h0; e.km = 4'h0;
        exp_q.push_back(e);
    endtask

    // One PS/2 bit; glitch adds a 2-cycle pulse in both the low and high phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        #PS2_Q;
        ps2_clk = 1'b0;
        if (glitch) begin
            #9000; ps2_clk = 1'b1; #1000; ps2_clk = 1'b0; #5000;
        end else begin
            #PS2_H;
        end
        ps2_clk = 1'b1;
        if (glitch) begin
            #6500; ps2_clk = 1'b0; #1000; ps2_clk = 1'b1;
        end else begin
            #PS2_Q;
        end
    endtask

    // Sends the first nbits of a frame (11 = full frame).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i], glitch && (i >= 2 && i <= 5));
        end
        ps2_data = 1'b1;
        #PS2_H;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic check_idle_outputs(input string name);
        @(negedge clk);
        assert_cnt++;
        if ({key_down, key_make, scan_valid, scan_code, scan_break, scan_ext, frame_err} != '0) begin
            fail_cnt++;
            $display("FAIL %s: kd=%b km=%b sv=%b code=%h brk=%b ext=%b err=%b, required all 0",
                     name, key_down, key_make, scan_valid, scan_code, scan_break, scan_ext, frame_err);
        end
    endtask

    // Monitor: compare every presented event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_valid || frame_err) begin
                assert_cnt++;
                if (exp_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL unexpected_event: sv=%b err=%b code=%h, required no event",
                             scan_valid, frame_err, scan_code);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        if (!(frame_err && !scan_valid)) begin
                            fail_cnt++;
                            $display("FAIL frame_err_event: err=%b sv=%b, required err=1 sv=0",
                                     frame_err, scan_valid);
                        end else begin
                            $display("event frame_err");
                        end
                    end else if (!(scan_valid && !frame_err && scan_code == e.code && scan_break == e.brk &&
                                   scan_ext == e.ext && key_down == e.kd && key_make == e.km)) begin
                        fail_cnt++;
                        $display("FAIL scan_event: sv=%b err=%b code=%h brk=%b ext=%b kd=%b km=%b, required sv=1 err=0 code=%h brk=%b ext=%b kd=%b km=%b",
                                 scan_valid, frame_err, scan_code, scan_break, scan_ext, key_down, key_make,
                                 e.code, e.brk, e.ext, e.kd, e.km);
                    end else begin
                        $display("event scan code=%h brk=%b ext=%b kd=%b km=%b",
                                 scan_code, scan_break, scan_ext, key_down, key_make);
                    end
                end
            end else if (key_make != 4'b0000) begin
                assert_cnt++;
                fail_cnt++;
                $display("FAIL stray_make: km=%b without scan_valid, required 0000", key_make);
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // W press and release.
        exp_scan(8'h1D, 1'b0, 1'b0, 4'b0001, 4'b0001);
        send(8'h1D);
        exp_scan(8'h1D, 1'b1, 1'b0, 4'b0000, 4'b0000);
        send(8'hF0); send(8'h1D);

        // A typematic: one make pulse, held until break.
        exp_scan(8'h1C, 1'b0, 1'b0, 4'b0010, 4'b0010);
        exp_scan(8'h1C, 1'b0, 1'b0, 4'b0010, 4'b0000);
        exp_scan(8'h1C, 1'b0, 1'b0, 4'b0010, 4'b0000);
        send(8'h1C); send(8'h1C); send(8'h1C);
        exp_scan(8'h1C, 1'b1, 1'b0, 4'b0000, 4'b0000);
        send(8'hF0); send(8'h1C);

        // Extended codes, both prefix orders, never touch keys.
        exp_scan(8'h1D, 1'b0, 1'b1, 4'b0000, 4'b0000);
        send(8'hE0); send(8'h1D);
        exp_scan(8'h1D, 1'b1, 1'b1, 4'b0000, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h1D);
        exp_scan(8'h1C, 1'b1, 1'b1, 4'b0000, 4'b0000);
        send(8'hF0); send(8'hE0); send(8'h1C);

        // Parity error after an F0 prefix: the error drops the prefix.
        exp_err();
        send(8'hF0);
        send_frame(8'h23, 1'b1, 1'b0, 11);
        exp_scan(8'h23, 1'b0, 1'b0, 4'b1000, 4'b1000);
        send(8'h23);
        exp_scan(8'h23, 1'b1, 1'b0, 4'b0000, 4'b0000);
        send(8'hF0); send(8'h23);

        // Timeout after start + 4 data bits.
        exp_err();
        send_frame(8'h1B, 1'b0, 1'b0, 5);
        repeat (TIMEOUT_CYC + 10) @(posedge clk);
        exp_scan(8'h1B, 1'b0, 1'b0, 4'b0100, 4'b0100);
        send(8'h1B);
        exp_scan(8'h1B, 1'b1, 1'b0, 4'b0000, 4'b0000);
        send(8'hF0); send(8'h1B);

        // Glitched clock: no bit slip.
        exp_scan(8'h1D, 1'b0, 1'b0, 4'b0001, 4'b0001);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        @(negedge clk);
        assert_cnt++;
        if (key_down != 4'b0001) begin
            fail_cnt++;
            $display("FAIL held_before_reset: kd=%b, required 0001", key_down);
        end

        // E0 prefix then partial frame, then reset mid-frame.
        send(8'hE0);
        send_frame(8'h1D, 1'b0, 1'b0, 3);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("after_mid_reset");
        repeat (10) @(posedge clk);
        check_idle_outputs("idle_after_reset");

        // Prefix and key state were wiped: plain make of A.
        exp_scan(8'h1C, 1'b0, 1'b0, 4'b0010, 4'b0010);
        send(8'h1C);

        repeat (50) @(posedge clk);
        @(negedge clk);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL missing_events: %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
